// File: rtl/fault_reg_bank_pkg.sv
// Shared fault-kind codes, FSM states and sizing helper for fault_reg_bank.
package fault_pkg;

    localparam logic [1:0] FK_FLIP   = 2'd0;
    localparam logic [1:0] FK_STUCK0 = 2'd1;
    localparam logic [1:0] FK_STUCK1 = 2'd2;
    localparam logic [1:0] FK_CLEAR  = 2'd3;

    typedef enum logic {
        ST_IDLE,
        ST_ARMED
    } fault_state_t;

    function automatic int fault_bw(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/fault_reg_bank_if.sv
// Valid/ready fault request port.
interface fault_reg_bank_if
    import fault_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int DELAY_W = 8,
    parameter int BW      = fault_bw(WIDTH)
);

    logic               f_valid;
    logic               f_ready;
    logic [1:0]         f_kind;
    logic [BW-1:0]      f_bit;
    logic [DELAY_W-1:0] f_delay;

    modport master (
        output f_valid, f_kind, f_bit, f_delay,
        input  f_ready
    );

    modport slave (
        input  f_valid, f_kind, f_bit, f_delay,
        output f_ready
    );

endinterface

// File: rtl/fault_reg_bank_timer.sv
// Fault request latch, delay countdown and one-cycle apply strobe.
module fault_timer
    import fault_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int DELAY_W = 8,
    parameter int BW      = fault_bw(WIDTH)
) (
    input  logic            clk,
    input  logic            rst_n,
    fault_reg_bank_if.slave f,
    output logic [1:0]      kind_o,
    output logic [BW-1:0]   bit_o,
    output logic            apply_o
);

    fault_state_t       state_q, state_d;
    logic [DELAY_W-1:0] cnt_q, cnt_d;
    logic [1:0]         kind_q, kind_d;
    logic [BW-1:0]      bit_q, bit_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            kind_q  <= '0;
            bit_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            kind_q  <= kind_d;
            bit_q   <= bit_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        kind_d  = kind_q;
        bit_d   = bit_q;
        apply_o = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (f.f_valid) begin
                    kind_d  = f.f_kind;
                    bit_d   = f.f_bit;
                    cnt_d   = f.f_delay;
                    state_d = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    apply_o = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign f.f_ready = (state_q == ST_IDLE);
    assign kind_o    = kind_q;
    assign bit_o     = bit_q;

endmodule

// File: rtl/fault_reg_bank.sv
// D register bank with stuck-at output masks and scheduled bit flips.
// Define FAULT_REGISTER_EN for simulation-only site/injection reporting.
module fault_reg_bank
    import fault_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int DELAY_W = 8,
    parameter int CNT_W   = 8,
    parameter int BW      = fault_bw(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    fault_reg_bank_if.slave  f,
    output logic             fired,
    output logic [CNT_W-1:0] fault_count
);

    logic [WIDTH-1:0] q_int_q, q_int_d;
    logic [WIDTH-1:0] s0_q, s0_d;
    logic [WIDTH-1:0] s1_q, s1_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fired_q;
    logic [1:0]       kind;
    logic [BW-1:0]    bit_w;
    logic             apply;
    logic             bit_ok;

    fault_timer #(
        .WIDTH   (WIDTH),
        .DELAY_W (DELAY_W),
        .BW      (BW)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .f       (f),
        .kind_o  (kind),
        .bit_o   (bit_w),
        .apply_o (apply)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_int_q <= '0;
            s0_q    <= '0;
            s1_q    <= '0;
            cnt_q   <= '0;
            fired_q <= 1'b0;
        end else begin
            q_int_q <= q_int_d;
            s0_q    <= s0_d;
            s1_q    <= s1_d;
            cnt_q   <= cnt_d;
            fired_q <= apply;
        end
    end

    assign bit_ok = (int'(bit_w) < WIDTH);

    // A flip acts on the value being loaded this edge, not the old one.
    always_comb begin
        q_int_d = en ? d : q_int_q;
        s0_d    = s0_q;
        s1_d    = s1_q;
        cnt_d   = cnt_q;
        if (apply) begin
            unique case (kind)
                FK_FLIP: begin
                    if (bit_ok) q_int_d[bit_w] = ~q_int_d[bit_w];
                end
                FK_STUCK0: begin
                    if (bit_ok) begin
                        s0_d[bit_w] = 1'b1;
                        s1_d[bit_w] = 1'b0;
                    end
                end
                FK_STUCK1: begin
                    if (bit_ok) begin
                        s1_d[bit_w] = 1'b1;
                        s0_d[bit_w] = 1'b0;
                    end
                end
                FK_CLEAR: begin
                    s0_d = '0;
                    s1_d = '0;
                end
                default: ;
            endcase
            if (kind != FK_CLEAR && bit_ok && cnt_q != '1)
                cnt_d = cnt_q + 1'b1;
        end
    end

    assign q           = (q_int_q & ~s0_q) | s1_q;
    assign fired       = fired_q;
    assign fault_count = cnt_q;

`ifdef FAULT_REGISTER_EN
    initial begin
        for (int i = 0; i < WIDTH; i++) begin
            $display("register %m.stuck_0_q[%0d] output", i);
            $display("register %m.stuck_1_q[%0d] output", i);
        end
    end

    always @(posedge clk) begin
        if (rst_n && apply)
            $display("inject %m kind=%0d bit=%0d t=%0t",
                     kind, bit_w, $time);
    end
`endif

endmodule

// File: tb/tb_fault_reg_bank.sv
// Directed vector bench for fault_reg_bank.
module tb_fault_reg_bank;
    import fault_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [7:0] d;
    logic [7:0] q;
    logic       fired;
    logic [7:0] fault_count;

    int checks = 0;
    int failures = 0;

    fault_reg_bank_if #(.WIDTH(8), .DELAY_W(8)) fif ();

    fault_reg_bank #(
        .WIDTH   (8),
        .DELAY_W (8),
        .CNT_W   (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .d           (d),
        .q           (q),
        .f           (fif),
        .fired       (fired),
        .fault_count (fault_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic [7:0] d;
        logic       fv;
        logic [1:0] kind;
        logic [2:0] fbit;
        logic [7:0] dly;
        logic [7:0] eq;
        logic       erdy;
        logic       efired;
        logic [7:0] ecnt;
    } vec_t;

    vec_t tv[25];

    function automatic vec_t mk(
        input logic en_, input logic [7:0] d_,
        input logic fv_, input logic [1:0] k_,
        input logic [2:0] b_, input logic [7:0] dl_,
        input logic [7:0] eq_, input logic erdy_,
        input logic efired_, input logic [7:0] ecnt_);
        vec_t v;
        v.en = en_; v.d = d_; v.fv = fv_; v.kind = k_;
        v.fbit = b_; v.dly = dl_; v.eq = eq_; v.erdy = erdy_;
        v.efired = efired_; v.ecnt = ecnt_;
        return v;
    endfunction

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic [7:0] eq,
                           input logic erdy, input logic efired,
                           input logic [7:0] ecnt);
        chk({tag, ".q"}, int'(q), int'(eq));
        chk({tag, ".ready"}, int'(fif.f_ready), int'(erdy));
        chk({tag, ".fired"}, int'(fired), int'(efired));
        chk({tag, ".count"}, int'(fault_count), int'(ecnt));
    endtask

    task automatic req(input logic fv, input logic [1:0] k,
                       input logic [2:0] b, input logic [7:0] dl);
        fif.f_valid = fv;
        fif.f_kind  = k;
        fif.f_bit   = b;
        fif.f_delay = dl;
    endtask

    int fired_seen;

    initial begin
        // en, d, fv, kind, bit, dly | q, rdy, fired, count
        tv[0]  = mk(1, 8'hFF, 0, 0,         0, 0, 8'hFF, 1, 0, 0);
        tv[1]  = mk(1, 8'h00, 0, 0,         0, 0, 8'h00, 1, 0, 0);
        tv[2]  = mk(0, 8'h00, 1, FK_STUCK1, 3, 0, 8'h00, 0, 0, 0);
        tv[3]  = mk(0, 8'h00, 0, 0,         0, 0, 8'h08, 1, 1, 1);
        tv[4]  = mk(1, 8'h00, 0, 0,         0, 0, 8'h08, 1, 0, 1);
        tv[5]  = mk(1, 8'h5A, 0, 0,         0, 0, 8'h5A, 1, 0, 1);
        tv[6]  = mk(0, 8'h00, 1, FK_FLIP,   0, 4, 8'h5A, 0, 0, 1);
        tv[7]  = mk(0, 8'h00, 0, 0,         0, 0, 8'h5A, 0, 0, 1);
        tv[8]  = mk(0, 8'h00, 1, FK_CLEAR,  0, 0, 8'h5A, 0, 0, 1);
        tv[9]  = mk(0, 8'h00, 0, 0,         0, 0, 8'h5A, 0, 0, 1);
        tv[10] = mk(0, 8'h00, 0, 0,         0, 0, 8'h5A, 0, 0, 1);
        tv[11] = mk(0, 8'h00, 0, 0,         0, 0, 8'h5B, 1, 1, 2);
        tv[12] = mk(0, 8'h00, 0, 0,         0, 0, 8'h5B, 1, 0, 2);
        tv[13] = mk(0, 8'h00, 1, FK_CLEAR,  0, 0, 8'h5B, 0, 0, 2);
        tv[14] = mk(0, 8'h00, 0, 0,         0, 0, 8'h5B, 1, 1, 2);
        tv[15] = mk(0, 8'h00, 1, FK_FLIP,   7, 0, 8'h5B, 0, 0, 2);
        tv[16] = mk(1, 8'h01, 0, 0,         0, 0, 8'h81, 1, 1, 3);
        tv[17] = mk(1, 8'h01, 0, 0,         0, 0, 8'h01, 1, 0, 3);
        tv[18] = mk(1, 8'h02, 0, 0,         0, 0, 8'h02, 1, 0, 3);
        tv[19] = mk(0, 8'h00, 1, FK_STUCK0, 1, 0, 8'h02, 0, 0, 3);
        tv[20] = mk(0, 8'h00, 0, 0,         0, 0, 8'h00, 1, 1, 4);
        tv[21] = mk(0, 8'h00, 1, FK_STUCK1, 1, 0, 8'h00, 0, 0, 4);
        tv[22] = mk(0, 8'h00, 0, 0,         0, 0, 8'h02, 1, 1, 5);
        tv[23] = mk(0, 8'h00, 1, FK_CLEAR,  0, 0, 8'h02, 0, 0, 5);
        tv[24] = mk(0, 8'h00, 0, 0,         0, 0, 8'h02, 1, 1, 5);

        rst_n = 1'b0;
        en    = 1'b1;
        d     = 8'hFF;
        req(0, 0, 0, 0);
        #12;
        chk_all("reset", 8'h00, 1, 0, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 25; i++) begin
            en = tv[i].en;
            d  = tv[i].d;
            req(tv[i].fv, tv[i].kind, tv[i].fbit, tv[i].dly);
            @(posedge clk);
            #1;
            chk_all($sformatf("vec%0d", i), tv[i].eq, tv[i].erdy,
                    tv[i].efired, tv[i].ecnt);
        end

        // Saturation: 260 counted faults on an 8-bit counter.
        en = 1'b0;
        for (int i = 0; i < 260; i++) begin
            req(1, FK_STUCK1, 0, 0);
            @(posedge clk);
            #1;
            req(0, 0, 0, 0);
            @(posedge clk);
            #1;
        end
        chk_all("sat", 8'h03, 1, 1, 8'hFF);

        // Reset while a delayed fault is pending.
        req(1, FK_STUCK1, 2, 8'd20);
        @(posedge clk);
        #1;
        req(0, 0, 0, 0);
        chk("arm.ready", int'(fif.f_ready), 0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
        end
        chk("armed.ready", int'(fif.f_ready), 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("rst_armed", 8'h00, 1, 0, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        en = 1'b1;
        d  = 8'hFF;
        @(posedge clk);
        #1;
        chk("post_rst.s0", int'(q), 8'hFF);
        d = 8'h00;
        @(posedge clk);
        #1;
        chk("post_rst.s1", int'(q), 8'h00);
        en = 1'b0;
        fired_seen = 0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk);
            #1;
            if (fired) fired_seen++;
        end
        chk("post_rst.fired", fired_seen, 0);
        chk_all("post_rst", 8'h00, 1, 0, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
